// File: rtl/result_out_pkg.sv
// Shared defaults for the result output FIFO: bus widths, the a0 register index
// and the occupancy-counter width helper.
package result_out_pkg;

   localparam int DATA_WIDTH    = 32;
   localparam int ADDRESS_WIDTH = 5;

   localparam logic [4:0] REG_A0 = 5'd10;

   // Occupancy needs one more bit than the pointers so that "full" is representable.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// FIFO storage: synchronous write, combinational read at the read pointer.
// Contents are intentionally not reset.
module result_fifo_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int PW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [PW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [PW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_out_fifo.sv
// Snoops register-file writes to TARGET_REG and buffers them for a valid/ready consumer.
// Optional RESULT_OUT_DEDUP_EN suppresses captures repeating the last captured value.
module result_out_fifo #(
   parameter int DATA_WIDTH    = result_out_pkg::DATA_WIDTH,
   parameter int ADDRESS_WIDTH = result_out_pkg::ADDRESS_WIDTH,
   parameter int DEPTH         = 8,
   parameter int TARGET_REG    = int'(result_out_pkg::REG_A0),
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     reg_wen,
   input  logic [ADDRESS_WIDTH-1:0] reg_waddr,
   input  logic [DATA_WIDTH-1:0]    reg_wdata,
   input  logic                     clear,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [CNT_WIDTH-1:0]     drop_count
);
   import result_out_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);
   localparam logic [ADDRESS_WIDTH-1:0] TGT    = ADDRESS_WIDTH'(TARGET_REG);
   localparam logic [LW-1:0]            LVL_FULL = LW'(DEPTH);

   logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] drop_q, drop_d;
   logic [DATA_WIDTH-1:0] rdata;
   logic                 cap, cap_eff, pop, full, push, drop;

   // x0 is hardwired zero, so a TARGET_REG of 0 never captures anything.
   assign cap  = reg_wen && (reg_waddr == TGT) && (TARGET_REG != 0);
   assign pop  = out_valid && out_ready;
   assign full = (level_q == LVL_FULL);
   assign push = cap_eff && (!full || pop);
   assign drop = cap_eff && full && !pop;

`ifdef RESULT_OUT_DEDUP_EN
   logic [DATA_WIDTH-1:0] last_q;
   logic                  has_last_q;

   assign cap_eff = cap && !(has_last_q && (reg_wdata == last_q));

   // Dropped captures still count as "seen", so a repeat after a drop stays suppressed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q     <= '0;
         has_last_q <= 1'b0;
      end else if (clear) begin
         last_q     <= '0;
         has_last_q <= 1'b0;
      end else if (cap_eff) begin
         last_q     <= reg_wdata;
         has_last_q <= 1'b1;
      end
   end
`else
   assign cap_eff = cap;
`endif

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         drop_d   = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
         if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   result_fifo_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .PW        (PW)
   ) u_mem (
      .clk    (clk),
      .we_i   (push && !clear),
      .waddr_i(wr_ptr_q),
      .wdata_i(reg_wdata),
      .raddr_i(rd_ptr_q),
      .rdata_o(rdata)
   );

   assign out_valid  = (level_q != '0);
   assign out_data   = out_valid ? rdata : '0;
   assign level      = level_q;
   assign overflow   = ovf_q;
   assign drop_count = drop_q;

endmodule
